fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Single-outstanding instruction fetch front end. It issues one word read at
// a time on a valid/ready instruction bus, holds the returned word for the
// decoder until it is accepted, and follows redirects (jump, taken branch,
// trap, mret) from the execute side.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset_n        in   1   asynchronous active-low reset
//   mem_valid      out  1   instruction-bus request valid
//   mem_ready      in   1   bus response; mem_rdata valid in the same cycle
//   mem_address    out  32  word-aligned byte address of the request
//   mem_rdata      in   32  bus read data
//   instr_valid    out  1   held word available to the decoder
//   instr_ready    in   1   decoder accepts the held word
//   instr_data     out  32  held instruction word
//   instr_pc       out  32  address instr_data was fetched from
//   redirect_valid in   1   redirect request
//   redirect_pc    in   32  redirect target, bits [1:0] forced to 00
//
// States
//   BOOT  : one idle cycle after reset before the first request
//   FETCH : request to pc outstanding on the bus
//   DRAIN : request still outstanding, but its data is stale because a
//           redirect arrived; wait for the bus to finish, then restart at
//           target
//   HOLD  : word presented to the decoder, bus idle
//
// All outputs are decoded from registers only, so nothing depends
// combinationally on mem_rdata or instr_ready.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]  state_q,  state_d;
  logic [31:0] pc_q,     pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] idata_q,  idata_d;
  logic [31:0] ipc_q,    ipc_d;

  // Redirect targets are always word aligned; the low bits are dropped.
  logic [31:0] redir_pc;
  assign redir_pc = {redirect_pc[31:2], 2'b00};

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    idata_d  = idata_q;
    ipc_d    = ipc_q;

    case (state_q)
      S_BOOT: begin
        if (redirect_valid) pc_d = redir_pc;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (mem_ready) begin
          if (redirect_valid) begin
            // Returned word belongs to the old stream: drop it and
            // re-request at the target right away.
            pc_d = redir_pc;
          end else begin
            idata_d = mem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + 32'd4;   // wraps 0xFFFF_FFFC -> 0
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          // The bus request cannot be withdrawn, so keep pc (and hence
          // mem_address) put and park the new target until it completes.
          target_d = redir_pc;
          state_d  = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (redirect_valid) target_d = redir_pc;
        if (mem_ready) begin
          // A redirect in the completing cycle is newer than target_q.
          pc_d    = redirect_valid ? redir_pc : target_q;
          state_d = S_FETCH;
        end
      end

      S_HOLD: begin
        // Redirect wins over instr_ready: the held word is simply dropped.
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_FETCH;
        end else if (instr_ready) begin
          state_d = S_FETCH;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      target_q <= 32'd0;
      idata_q  <= 32'd0;
      ipc_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      idata_q  <= idata_d;
      ipc_q    <= ipc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (register-decoded only)
  // -------------------------------------------------------------------------
  assign mem_valid   = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign mem_address = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr_data  = idata_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid, mem_ready = 1'b0;
  logic [31:0] mem_address, mem_rdata = 32'd0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr_data, instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_address(mem_address), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle; outputs are sampled and inputs driven 2 units after
  // the rising edge.
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic idle_inputs();
    mem_ready = 0; mem_rdata = 0; instr_ready = 0;
    redirect_valid = 0; redirect_pc = 0;
  endtask

  // Leaves the DUT in BOOT with reset released mid-cycle.
  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    mem_ready = 1; instr_ready = 1;
    tick();
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    checks++; if (instr_data !== 32'd0) begin failures++; $display("FAIL reset_instr_data got=%h exp=0", instr_data); end
    checks++; if (instr_pc !== 32'd0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); end
    do_reset();
    #1;
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL boot_mem_valid got=%b exp=0", mem_valid); end
    tick();
    checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%b exp=1", mem_valid); end
    checks++; if (mem_address !== RST_PC) begin failures++; $display("FAIL first_req_addr got=%h exp=%h", mem_address, RST_PC); end
  endtask

  task automatic test_basic();
    int cnt;
    do_reset();
    mem_ready = 1; mem_rdata = 32'h0000_0013;
    tick();
    checks++; if (mem_address !== 32'd0 || mem_valid !== 1'b1) begin failures++; $display("FAIL basic_req got=%b/%h exp=1/0", mem_valid, mem_address); end
    tick();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", instr_valid); end
    checks++; if (instr_data !== 32'h13) begin failures++; $display("FAIL basic_data got=%h exp=00000013", instr_data); end
    checks++; if (instr_pc !== 32'd0) begin failures++; $display("FAIL basic_pc got=%h exp=0", instr_pc); end
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL basic_bus_idle got=%b exp=0", mem_valid); end
    instr_ready = 1;
    tick();
    checks++; if (mem_address !== 32'd4 || mem_valid !== 1'b1) begin failures++; $display("FAIL basic_next_addr got=%b/%h exp=1/4", mem_valid, mem_address); end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (instr_valid === 1'b1) cnt++;
    end
    checks++; if (cnt != 5) begin failures++; $display("FAIL throughput got=%0d exp=5", cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (mem_valid !== 1'b1 || mem_address !== RST_PC || instr_valid !== 1'b0)
        begin failures++; $display("FAIL stall_c%0d got=%b/%h/%b exp=1/%h/0", i, mem_valid, mem_address, instr_valid, RST_PC); end
    end
  endtask

  // Continues from the stalled FETCH left by test_stall.
  task automatic test_hold();
    mem_ready = 1; mem_rdata = 32'hA5A5_1234;
    tick();
    mem_ready = 0; mem_rdata = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_data !== 32'hA5A5_1234 || instr_pc !== RST_PC || mem_valid !== 1'b0)
        begin failures++; $display("FAIL hold_c%0d got=%b/%h/%h/%b exp=1/a5a51234/%h/0", i, instr_valid, instr_data, instr_pc, mem_valid, RST_PC); end
    end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    checks++; if (mem_valid !== 1'b1 || mem_address !== RST_PC + 32'd4) begin failures++; $display("FAIL hold_release got=%b/%h exp=1/%h", mem_valid, mem_address, RST_PC + 32'd4); end
  endtask

  task automatic test_drain();
    do_reset();
    tick();
    redirect_valid = 1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 0;
    checks++; if (mem_valid !== 1'b1 || mem_address !== 32'd0) begin failures++; $display("FAIL drain_keep_req got=%b/%h exp=1/0", mem_valid, mem_address); end
    tick();
    checks++; if (mem_valid !== 1'b1 || mem_address !== 32'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL drain_wait got=%b/%h/%b exp=1/0/0", mem_valid, mem_address, instr_valid); end
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 0;
    checks++; if (instr_valid !== 1'b0 || mem_address !== 32'h100 || mem_valid !== 1'b1) begin failures++; $display("FAIL drain_restart got=%b/%h/%b exp=0/100/1", instr_valid, mem_address, mem_valid); end
    tick();
    checks++; if (instr_valid !== 1'b0 || instr_data === 32'hDEAD_BEEF) begin failures++; $display("FAIL drain_dropped got=%b/%h exp=0/not-deadbeef", instr_valid, instr_data); end
    // Redirect coinciding with bus completion in DRAIN wins.
    redirect_valid = 1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h404; mem_ready = 1;
    tick();
    redirect_valid = 0; mem_ready = 0;
    checks++; if (mem_address !== 32'h404 || instr_valid !== 1'b0) begin failures++; $display("FAIL drain_same_cycle got=%h/%b exp=404/0", mem_address, instr_valid); end
    // Successive redirects while draining: newest target wins.
    redirect_valid = 1; redirect_pc = 32'h500;
    tick();
    redirect_pc = 32'h600;
    tick();
    redirect_valid = 0; mem_ready = 1;
    tick();
    mem_ready = 0;
    checks++; if (mem_address !== 32'h600 || mem_valid !== 1'b1) begin failures++; $display("FAIL drain_newest got=%b/%h exp=1/600", mem_valid, mem_address); end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    mem_ready = 1; mem_rdata = 32'h0000_0077;
    tick(); tick();
    mem_ready = 0;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL hredir_setup got=%b exp=1", instr_valid); end
    redirect_valid = 1; redirect_pc = 32'h0000_0203; instr_ready = 1;
    tick();
    redirect_valid = 0; instr_ready = 0;
    checks++; if (instr_valid !== 1'b0 || mem_valid !== 1'b1 || mem_address !== 32'h200) begin failures++; $display("FAIL hredir got=%b/%b/%h exp=0/1/200", instr_valid, mem_valid, mem_address); end
  endtask

  task automatic test_boot_redirect();
    do_reset();
    redirect_valid = 1; redirect_pc = 32'h0000_0041;
    tick();
    redirect_valid = 0;
    checks++; if (mem_valid !== 1'b1 || mem_address !== 32'h40) begin failures++; $display("FAIL boot_redirect got=%b/%h exp=1/40", mem_valid, mem_address); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    mem_ready = 1; mem_rdata = 32'h1111_1111;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 0; mem_rdata = 32'h2222_2222;
    checks++; if (mem_address !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin failures++; $display("FAIL wrap_redirect got=%h/%b exp=fffffffc/0", mem_address, instr_valid); end
    tick();
    mem_ready = 0; instr_ready = 1;
    checks++; if (instr_pc !== 32'hFFFF_FFFC || instr_data !== 32'h2222_2222) begin failures++; $display("FAIL wrap_word got=%h/%h exp=fffffffc/22222222", instr_pc, instr_data); end
    tick();
    instr_ready = 0;
    checks++; if (mem_address !== 32'd0 || mem_valid !== 1'b1) begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/0", mem_valid, mem_address); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_ready = 1; mem_rdata = 32'hCAFE_0001;
    tick(); tick();
    mem_ready = 0; instr_ready = 1;
    tick();
    instr_ready = 0; redirect_valid = 1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 0;
    #1 reset_n = 0;
    #1;
    checks++; if (mem_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL async_rst_ctrl got=%b/%b exp=0/0", mem_valid, instr_valid); end
    checks++; if (instr_data !== 32'd0 || instr_pc !== 32'd0) begin failures++; $display("FAIL async_rst_regs got=%h/%h exp=0/0", instr_data, instr_pc); end
    tick();
    reset_n = 1;
    tick();
    checks++; if (mem_valid !== 1'b1 || mem_address !== RST_PC) begin failures++; $display("FAIL async_rst_restart got=%b/%h exp=1/%h", mem_valid, mem_address, RST_PC); end
  endtask

  // Reference model: tracks what the bus and the decoder port are doing
  // (booting, word held, stale request outstanding) and the next address.
  task automatic test_random();
    bit          m_boot, m_held, m_stale;
    logic [31:0] m_pc, m_tgt, m_word, m_wpc, r;
    do_reset();
    m_boot = 1; m_held = 0; m_stale = 0;
    m_pc = RST_PC; m_tgt = 0; m_word = 0; m_wpc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++; if (mem_valid !== (!m_boot && !m_held)) begin failures++; $display("FAIL rnd_mem_valid c%0d got=%b exp=%b", cyc, mem_valid, !m_boot && !m_held); end
      checks++; if (instr_valid !== m_held) begin failures++; $display("FAIL rnd_instr_valid c%0d got=%b exp=%b", cyc, instr_valid, m_held); end
      if (!m_boot && !m_held) begin
        checks++; if (mem_address !== m_pc) begin failures++; $display("FAIL rnd_addr c%0d got=%h exp=%h", cyc, mem_address, m_pc); end
      end
      if (m_held) begin
        checks++; if (instr_data !== m_word || instr_pc !== m_wpc) begin failures++; $display("FAIL rnd_word c%0d got=%h@%h exp=%h@%h", cyc, instr_data, instr_pc, m_word, m_wpc); end
      end
      redirect_valid = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 2))
        0: redirect_pc = $urandom;
        1: redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: redirect_pc = $urandom & 32'h3FF;
      endcase
      mem_ready   = $urandom_range(0, 1);
      mem_rdata   = $urandom;
      instr_ready = ($urandom_range(0, 4) < 3);
      r = redirect_pc & 32'hFFFF_FFFC;
      if (m_boot) begin
        if (redirect_valid) m_pc = r;
        m_boot = 0;
      end else if (m_held) begin
        if (redirect_valid) begin m_pc = r; m_held = 0; end
        else if (instr_ready) m_held = 0;
      end else if (m_stale) begin
        if (redirect_valid) m_tgt = r;
        if (mem_ready) begin m_pc = m_tgt; m_stale = 0; end
      end else begin
        if (mem_ready && redirect_valid) m_pc = r;
        else if (mem_ready) begin m_word = mem_rdata; m_wpc = m_pc; m_pc = m_pc + 32'd4; m_held = 1; end
        else if (redirect_valid) begin m_tgt = r; m_stale = 1; end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hold();
    test_drain();
    test_hold_redirect();
    test_boot_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
